// File: rtl/pipe_regs.sv
// Four-stage pipeline register bank (IFID, IDEX, EXMEM, MEMWB) with a
// downstream-to-upstream hold chain, bubble insertion, flush and a stall counter.
module pipe_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [3:0]  Rd_in,
    input  logic [3:0]  Rs_in,
    input  logic [3:0]  Rt_in,
    input  logic        valid_in,
    input  logic        flush,
    input  logic        IFID_stall,
    input  logic        IDEX_stall,
    input  logic        EXMEM_stall,
    input  logic        MEMWB_stall,
    output logic [3:0]  IFID_Rd_ff,
    output logic [3:0]  IFID_Rs_ff,
    output logic [3:0]  IFID_Rt_ff,
    output logic [3:0]  IDEX_Rd_ff,
    output logic [3:0]  IDEX_Rs_ff,
    output logic [3:0]  IDEX_Rt_ff,
    output logic [3:0]  EXMEM_Rd_ff,
    output logic [3:0]  EXMEM_Rs_ff,
    output logic [3:0]  EXMEM_Rt_ff,
    output logic [3:0]  MEMWB_Rd_ff,
    output logic [3:0]  MEMWB_Rs_ff,
    output logic [3:0]  MEMWB_Rt_ff,
    output logic        IFID_vld,
    output logic        IDEX_vld,
    output logic        EXMEM_vld,
    output logic        MEMWB_vld,
    output logic [15:0] instr_2ID_ff,
    output logic        in_ready,
    output logic [15:0] stall_cycles
);

    typedef struct packed {
        logic       vld;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
    } stage_t;

    localparam stage_t      BUBBLE = '{vld: 1'b0, rd: 4'h0, rs: 4'h0, rt: 4'h0};
    localparam logic [15:0] NOP    = 16'h0800;

    stage_t      ifid_r, idex_r, exmem_r, memwb_r;
    stage_t      ifid_nxt_s, idex_nxt_s, exmem_nxt_s, memwb_nxt_s;
    logic [15:0] instr_r, instr_nxt_s;
    logic [15:0] stall_cnt_r;
    logic        hold_memwb_s, hold_exmem_s, hold_idex_s, hold_ifid_s;

    // Hold requests ripple upstream: a held stage freezes everything behind it.
    always_comb begin
        hold_memwb_s = MEMWB_stall;
        hold_exmem_s = EXMEM_stall | hold_memwb_s;
        hold_idex_s  = IDEX_stall  | hold_exmem_s;
        hold_ifid_s  = IFID_stall  | hold_idex_s;
    end

    // Next-state selection per stage: flush, hold, bubble, or advance.
    always_comb begin
        ifid_nxt_s  = ifid_r;
        instr_nxt_s = instr_r;
        idex_nxt_s  = idex_r;
        exmem_nxt_s = exmem_r;
        memwb_nxt_s = memwb_r;

        if (flush) begin
            ifid_nxt_s  = BUBBLE;
            instr_nxt_s = NOP;
        end else if (hold_ifid_s) begin
            ifid_nxt_s  = ifid_r;
            instr_nxt_s = instr_r;
        end else begin
            ifid_nxt_s  = '{vld: valid_in, rd: Rd_in, rs: Rs_in, rt: Rt_in};
            instr_nxt_s = instr_in;
        end

        if (flush) begin
            idex_nxt_s = BUBBLE;
        end else if (hold_idex_s) begin
            idex_nxt_s = idex_r;
        end else if (hold_ifid_s) begin
            idex_nxt_s = BUBBLE;
        end else begin
            idex_nxt_s = ifid_r;
        end

        if (hold_exmem_s) begin
            exmem_nxt_s = exmem_r;
        end else if (hold_idex_s) begin
            exmem_nxt_s = BUBBLE;
        end else begin
            exmem_nxt_s = idex_r;
        end

        if (hold_memwb_s) begin
            memwb_nxt_s = memwb_r;
        end else if (hold_exmem_s) begin
            memwb_nxt_s = BUBBLE;
        end else begin
            memwb_nxt_s = exmem_r;
        end
    end

    // Stage registers and saturating stall counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_r      <= BUBBLE;
            instr_r     <= NOP;
            idex_r      <= BUBBLE;
            exmem_r     <= BUBBLE;
            memwb_r     <= BUBBLE;
            stall_cnt_r <= 16'h0000;
        end else begin
            ifid_r  <= ifid_nxt_s;
            instr_r <= instr_nxt_s;
            idex_r  <= idex_nxt_s;
            exmem_r <= exmem_nxt_s;
            memwb_r <= memwb_nxt_s;
            if (hold_ifid_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign in_ready     = ~rst & ~hold_ifid_s;
    assign stall_cycles = stall_cnt_r;
    assign instr_2ID_ff = instr_r;

    assign IFID_vld    = ifid_r.vld;
    assign IFID_Rd_ff  = ifid_r.rd;
    assign IFID_Rs_ff  = ifid_r.rs;
    assign IFID_Rt_ff  = ifid_r.rt;
    assign IDEX_vld    = idex_r.vld;
    assign IDEX_Rd_ff  = idex_r.rd;
    assign IDEX_Rs_ff  = idex_r.rs;
    assign IDEX_Rt_ff  = idex_r.rt;
    assign EXMEM_vld   = exmem_r.vld;
    assign EXMEM_Rd_ff = exmem_r.rd;
    assign EXMEM_Rs_ff = exmem_r.rs;
    assign EXMEM_Rt_ff = exmem_r.rt;
    assign MEMWB_vld   = memwb_r.vld;
    assign MEMWB_Rd_ff = memwb_r.rd;
    assign MEMWB_Rs_ff = memwb_r.rs;
    assign MEMWB_Rt_ff = memwb_r.rt;

endmodule

// File: tb/tb_pipe_regs.sv
// Self-checking bench for pipe_regs: a stage-array reference model compared
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_pipe_regs;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic [3:0]  Rd_in, Rs_in, Rt_in;
    logic        valid_in, flush;
    logic        IFID_stall, IDEX_stall, EXMEM_stall, MEMWB_stall;
    logic [3:0]  IFID_Rd_ff, IFID_Rs_ff, IFID_Rt_ff;
    logic [3:0]  IDEX_Rd_ff, IDEX_Rs_ff, IDEX_Rt_ff;
    logic [3:0]  EXMEM_Rd_ff, EXMEM_Rs_ff, EXMEM_Rt_ff;
    logic [3:0]  MEMWB_Rd_ff, MEMWB_Rs_ff, MEMWB_Rt_ff;
    logic        IFID_vld, IDEX_vld, EXMEM_vld, MEMWB_vld;
    logic [15:0] instr_2ID_ff;
    logic        in_ready;
    logic [15:0] stall_cycles;

    pipe_regs dut (
        .clk(clk), .rst(rst), .instr_in(instr_in),
        .Rd_in(Rd_in), .Rs_in(Rs_in), .Rt_in(Rt_in),
        .valid_in(valid_in), .flush(flush),
        .IFID_stall(IFID_stall), .IDEX_stall(IDEX_stall),
        .EXMEM_stall(EXMEM_stall), .MEMWB_stall(MEMWB_stall),
        .IFID_Rd_ff(IFID_Rd_ff), .IFID_Rs_ff(IFID_Rs_ff), .IFID_Rt_ff(IFID_Rt_ff),
        .IDEX_Rd_ff(IDEX_Rd_ff), .IDEX_Rs_ff(IDEX_Rs_ff), .IDEX_Rt_ff(IDEX_Rt_ff),
        .EXMEM_Rd_ff(EXMEM_Rd_ff), .EXMEM_Rs_ff(EXMEM_Rs_ff), .EXMEM_Rt_ff(EXMEM_Rt_ff),
        .MEMWB_Rd_ff(MEMWB_Rd_ff), .MEMWB_Rs_ff(MEMWB_Rs_ff), .MEMWB_Rt_ff(MEMWB_Rt_ff),
        .IFID_vld(IFID_vld), .IDEX_vld(IDEX_vld), .EXMEM_vld(EXMEM_vld), .MEMWB_vld(MEMWB_vld),
        .instr_2ID_ff(instr_2ID_ff), .in_ready(in_ready), .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: index 0=IFID .. 3=MEMWB
    logic        m_vld [4];
    logic [3:0]  m_rd  [4];
    logic [3:0]  m_rs  [4];
    logic [3:0]  m_rt  [4];
    logic [15:0] m_instr;
    int          m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hold(input int k);
        logic [3:0] st;
        st = {MEMWB_stall, EXMEM_stall, IDEX_stall, IFID_stall};
        model_hold = 1'b0;
        for (int j = k; j < 4; j++) model_hold = model_hold | st[j];
    endfunction

    task automatic model_bubble(input int k);
        m_vld[k] = 1'b0; m_rd[k] = 4'h0; m_rs[k] = 4'h0; m_rt[k] = 4'h0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        if (rst) begin
            for (int k = 0; k < 4; k++) model_bubble(k);
            m_instr = 16'h0800;
            m_cnt   = 0;
        end else begin
            if (model_hold(0) && m_cnt < 65535) m_cnt = m_cnt + 1;
            for (int k = 3; k >= 1; k--) begin
                if (k == 1 && flush) model_bubble(k);
                else if (model_hold(k)) ;
                else if (model_hold(k - 1)) model_bubble(k);
                else begin
                    m_vld[k] = m_vld[k-1]; m_rd[k] = m_rd[k-1];
                    m_rs[k] = m_rs[k-1];   m_rt[k] = m_rt[k-1];
                end
            end
            if (flush) begin
                model_bubble(0);
                m_instr = 16'h0800;
            end else if (!model_hold(0)) begin
                m_vld[0] = valid_in; m_rd[0] = Rd_in; m_rs[0] = Rs_in; m_rt[0] = Rt_in;
                m_instr = instr_in;
            end
        end
    endtask

    // Check in_ready against the model, then run one clock and land on the falling edge.
    task automatic tick();
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, (!rst && !model_hold(0))});
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] ins, input logic [3:0] rd, input logic v);
        instr_in = ins; Rd_in = rd; Rs_in = rd + 4'd1; Rt_in = rd + 4'd2; valid_in = v;
    endtask

    task automatic set_stall(input logic a, input logic b, input logic c, input logic d);
        IFID_stall = a; IDEX_stall = b; EXMEM_stall = c; MEMWB_stall = d;
    endtask

    // Per-cycle comparison of all registered outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ifid",  {19'h0, IFID_vld,  IFID_Rd_ff,  IFID_Rs_ff,  IFID_Rt_ff},  {19'h0, m_vld[0], m_rd[0], m_rs[0], m_rt[0]});
            chk("idex",  {19'h0, IDEX_vld,  IDEX_Rd_ff,  IDEX_Rs_ff,  IDEX_Rt_ff},  {19'h0, m_vld[1], m_rd[1], m_rs[1], m_rt[1]});
            chk("exmem", {19'h0, EXMEM_vld, EXMEM_Rd_ff, EXMEM_Rs_ff, EXMEM_Rt_ff}, {19'h0, m_vld[2], m_rd[2], m_rs[2], m_rt[2]});
            chk("memwb", {19'h0, MEMWB_vld, MEMWB_Rd_ff, MEMWB_Rs_ff, MEMWB_Rt_ff}, {19'h0, m_vld[3], m_rd[3], m_rs[3], m_rt[3]});
            chk("instr", {16'h0, instr_2ID_ff}, {16'h0, m_instr});
            chk("stall_cycles", {16'h0, stall_cycles}, m_cnt);
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) model_bubble(k);
        m_instr = 16'h0800;
        m_cnt   = 0;
        rst = 1'b1; flush = 1'b0;
        set_in(16'h0000, 4'h0, 1'b0);
        set_stall(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset, with a stall request that must be ignored
        tick();
        cmp_en = 1'b1;
        set_stall(1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("lit_rst_in_ready", {31'h0, in_ready}, 32'h0);
        tick();
        chk("lit_rst_vld", {28'h0, IFID_vld, IDEX_vld, EXMEM_vld, MEMWB_vld}, 32'h0);
        chk("lit_rst_cnt", {16'h0, stall_cycles}, 32'h0);
        chk("lit_rst_nop", {16'h0, instr_2ID_ff}, 32'h0800);

        // Stream A, B, C with no stalls
        rst = 1'b0;
        set_stall(1'b0, 1'b0, 1'b0, 1'b0);
        set_in(16'h1234, 4'h1, 1'b1); tick();
        chk("lit_A_ifid", {16'h0, instr_2ID_ff}, 32'h1234);
        set_in(16'h2345, 4'h2, 1'b1); tick();
        set_in(16'h3456, 4'h3, 1'b1); tick();
        set_in(16'h0000, 4'h0, 1'b0); tick();
        chk("lit_A_memwb", {27'h0, MEMWB_vld, MEMWB_Rd_ff}, {27'h0, 1'b1, 4'h1});

        // A in IDEX, B in IFID, then IDEX_stall for two cycles
        set_in(16'h1234, 4'h1, 1'b1); tick();
        set_in(16'h2345, 4'h2, 1'b1); tick();
        set_in(16'h3456, 4'h3, 1'b1);
        set_stall(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1 chk("lit_stall_in_ready", {31'h0, in_ready}, 32'h0);
            tick();
            chk("lit_stall_exmem_vld", {31'h0, EXMEM_vld}, 32'h0);
            chk("lit_stall_idex", {27'h0, IDEX_vld, IDEX_Rd_ff}, {27'h0, 1'b1, 4'h1});
            chk("lit_stall_ifid", {16'h0, instr_2ID_ff}, 32'h2345);
        end
        chk("lit_stall_cnt2", {16'h0, stall_cycles}, 32'd2);
        set_stall(1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("lit_release_exmem", {27'h0, EXMEM_vld, EXMEM_Rd_ff}, {27'h0, 1'b1, 4'h1});

        // Fill all stages, then MEMWB_stall for one cycle
        set_in(16'h4567, 4'h4, 1'b1); tick();
        set_in(16'h5678, 4'h5, 1'b1);
        set_stall(1'b0, 1'b0, 1'b0, 1'b1); tick();
        chk("lit_memwb_hold_vld", {28'h0, IFID_vld, IDEX_vld, EXMEM_vld, MEMWB_vld}, 32'hF);
        chk("lit_memwb_hold_ifid", {16'h0, instr_2ID_ff}, 32'h4567);
        chk("lit_memwb_hold_rd", {16'h0, IDEX_Rd_ff, EXMEM_Rd_ff, MEMWB_Rd_ff, 4'h0}, 32'h3210);
        chk("lit_memwb_hold_cnt", {16'h0, stall_cycles}, 32'd3);

        // Advance so C sits in EXMEM, then flush
        set_stall(1'b0, 1'b0, 1'b0, 1'b0); tick();
        set_in(16'h6789, 4'h6, 1'b1); flush = 1'b1; tick();
        flush = 1'b0;
        chk("lit_flush_vld", {30'h0, IFID_vld, IDEX_vld}, 32'h0);
        chk("lit_flush_nop", {16'h0, instr_2ID_ff}, 32'h0800);
        chk("lit_flush_memwb", {27'h0, MEMWB_vld, MEMWB_Rd_ff}, {27'h0, 1'b1, 4'h3});

        // Flush while EXMEM is held
        set_in(16'h789A, 4'h6, 1'b1); tick();
        set_in(16'h89AB, 4'h7, 1'b1); tick();
        set_in(16'h9ABC, 4'h8, 1'b1); tick();
        set_in(16'hABCD, 4'h9, 1'b1); flush = 1'b1;
        set_stall(1'b0, 1'b0, 1'b1, 1'b0); tick();
        flush = 1'b0;
        chk("lit_flushhold_idex", {31'h0, IDEX_vld}, 32'h0);
        chk("lit_flushhold_exmem", {27'h0, EXMEM_vld, EXMEM_Rd_ff}, {27'h0, 1'b1, 4'h6});
        chk("lit_flushhold_memwb", {31'h0, MEMWB_vld}, 32'h0);

        // Mixed stall/flush/valid patterns
        for (int i = 0; i < 60; i++) begin
            set_in(16'hC000 + 16'(i), 4'(i), (i % 3) != 0);
            flush = (i % 9) == 4;
            set_stall((i % 7) == 3, (i % 5) == 2, (i % 11) == 6, (i % 13) == 9);
            tick();
        end
        flush = 1'b0;

        // Long IFID stall to saturate the counter
        set_in(16'h1111, 4'hA, 1'b1);
        set_stall(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) tick();
        chk("lit_sat", {16'h0, stall_cycles}, 32'hFFFF);
        tick();
        chk("lit_sat_hold", {16'h0, stall_cycles}, 32'hFFFF);

        // Reset during stall and flush
        rst = 1'b1; flush = 1'b1; tick();
        chk("lit_midrst_vld", {28'h0, IFID_vld, IDEX_vld, EXMEM_vld, MEMWB_vld}, 32'h0);
        chk("lit_midrst_cnt", {16'h0, stall_cycles}, 32'h0);
        rst = 1'b0; flush = 1'b0; tick();
        chk("lit_postrst_cnt", {16'h0, stall_cycles}, 32'd1);
        set_stall(1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("lit_postrst_load", {16'h0, instr_2ID_ff}, 32'h1111);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
